// File: rtl/phase_gen_tdm.sv
// Time-multiplexed phase generator: one channel per cycle through a 5-cycle fetch/vibrato/
// increment/accumulate pipeline sharing a single phase-accumulator array.
module phase_gen_tdm #(
  parameter int NUM_CH          = 36,
  parameter int FNUM_WIDTH      = 10,
  parameter int BLOCK_WIDTH     = 3,
  parameter int MULT_WIDTH      = 4,
  parameter int PHASE_ACC_WIDTH = 19,
  parameter int PHASE_OUT_WIDTH = 10,
  parameter int VIB_INDEX_WIDTH = 13,
  localparam int CH_W           = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_clk_en,
  output logic                       rd_en,
  output logic [CH_W-1:0]            rd_ch,
  input  logic [FNUM_WIDTH-1:0]      fnum,
  input  logic [BLOCK_WIDTH-1:0]     block,
  input  logic [MULT_WIDTH-1:0]      mult,
  input  logic                       vib,
  input  logic                       dvb,
  input  logic                       key_on,
  output logic                       phase_valid,
  output logic [CH_W-1:0]            phase_ch,
  output logic [PHASE_OUT_WIDTH-1:0] phase_out,
  output logic                       busy,
  output logic                       overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam int SH_W   = FNUM_WIDTH + (1 << BLOCK_WIDTH) - 1;
  localparam int PROD_W = SH_W + 5;
  localparam int SUM_W  = FNUM_WIDTH + 2;
  localparam logic signed [SUM_W-1:0] FNUM_MAX = SUM_W'((1 << FNUM_WIDTH) - 1);
  // Doubled multiple so mult=0 (x0.5) stays integral; halved again after the product.
  localparam logic [4:0] M2_TAB [16] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14,
                                         5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30};

  function automatic logic [FNUM_WIDTH-1:0] sat_fnum(input logic signed [SUM_W-1:0] s);
    if (s < 0) return '0;
    if (s > FNUM_MAX) return '1;
    return s[FNUM_WIDTH-1:0];
  endfunction

  function automatic logic [FNUM_WIDTH-1:0] vib_fnum(input logic [FNUM_WIDTH-1:0] f,
                                                     input logic en, input logic idx_hi,
                                                     input logic dv, input logic neg);
    logic signed [SUM_W-1:0] d;
    d = $signed({2'b00, f >> 7});
    if (idx_hi) d = d >>> 1;
    if (!dv) d = d >>> 1;
    if (neg) d = -d;
    if (!en) d = '0;
    return sat_fnum($signed({2'b00, f}) + d);
  endfunction

  function automatic logic [PHASE_ACC_WIDTH-1:0] calc_inc(input logic [FNUM_WIDTH-1:0] f,
                                                          input logic [BLOCK_WIDTH-1:0] b,
                                                          input logic [4:0] m2);
    logic [PROD_W-1:0] p;
    p = PROD_W'(f) << b;
    p = p * PROD_W'(m2);
    return PHASE_ACC_WIDTH'(p >> 1);
  endfunction

  logic [VIB_INDEX_WIDTH-1:0] vib_idx;
  logic                       vld_p0, vld_p1, vld_p2, vld_p3;
  logic [CH_W-1:0]            ch_p0, ch_p1, ch_p2, ch_p3;
  logic [FNUM_WIDTH-1:0]      fnum_p1, fnum_v_p2;
  logic [BLOCK_WIDTH-1:0]     block_p1, block_p2;
  logic [MULT_WIDTH-1:0]      mult_p1;
  logic [4:0]                 m2_p2;
  logic                       vib_p1, dvb_p1, key_on_p1, key_on_p2, key_on_p3;
  logic [PHASE_ACC_WIDTH-1:0] inc_p3, acc_sum;
  logic [PHASE_ACC_WIDTH-1:0] acc [NUM_CH];
  logic [NUM_CH-1:0]          key_on_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_ch   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      vib_idx <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
    end else begin
      overrun <= sample_clk_en && busy;
      if (sample_clk_en && !busy) begin
        busy    <= 1'b1;
        rd_en   <= 1'b1;
        rd_ch   <= '0;
        vib_idx <= vib_idx + 1'b1;
      end else begin
        if (rd_en) begin
          if (rd_ch == LAST_CH) rd_en <= 1'b0;
          else rd_ch <= rd_ch + 1'b1;
        end
        if (phase_valid && phase_ch == LAST_CH) busy <= 1'b0;
      end
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    // p0: register file answers the fetch issued last cycle
    ch_p0     <= rd_ch;
    // p1: capture channel parameters
    ch_p1     <= ch_p0;
    fnum_p1   <= fnum;
    block_p1  <= block;
    mult_p1   <= mult;
    vib_p1    <= vib;
    dvb_p1    <= dvb;
    key_on_p1 <= key_on;
    // p2: vibrato-adjusted fnum and multiple lookup
    ch_p2     <= ch_p1;
    fnum_v_p2 <= vib_fnum(fnum_p1, vib_p1, vib_idx[VIB_INDEX_WIDTH-2 -: 2] == 2'b11, dvb_p1,
                          vib_idx[VIB_INDEX_WIDTH-1]);
    block_p2  <= block_p1;
    m2_p2     <= M2_TAB[mult_p1];
    key_on_p2 <= key_on_p1;
    // p3: phase increment
    ch_p3     <= ch_p2;
    inc_p3    <= calc_inc(fnum_v_p2, block_p2, m2_p2);
    key_on_p3 <= key_on_p2;
  end

  assign acc_sum = acc[ch_p3] + inc_p3;

  // p4: accumulate or restart on key-on rising edge, and present the phase
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      key_on_prev <= '0;
      phase_valid <= 1'b0;
      phase_ch    <= '0;
      phase_out   <= '0;
    end else begin
      phase_valid <= vld_p3;
      if (vld_p3) begin
        key_on_prev[ch_p3] <= key_on_p3;
        phase_ch           <= ch_p3;
        if (key_on_p3 && !key_on_prev[ch_p3]) begin
          acc[ch_p3] <= '0;
          phase_out  <= '0;
        end else begin
          acc[ch_p3] <= acc_sum;
          phase_out  <= acc_sum[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
        end
      end
    end
  end

endmodule
